// File: rtl/pad_draw_fsm_if.sv
// Draw-request / pixel-stream bundle between the game controller (master) and the pad sequencer (slave).
// PAD_DRAW_CLEAR_EN adds the full-screen clear request.
interface pad_draw_fsm_if;
    logic       start;
    logic [1:0] pad_sel;
    logic       lit;
`ifdef PAD_DRAW_CLEAR_EN
    logic       clear;
`endif
    logic       busy;
    logic       done;
    logic       plot;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;

`ifdef PAD_DRAW_CLEAR_EN
    modport master (
        output start, pad_sel, lit, clear,
        input  busy, done, plot, x_out, y_out, colour_out
    );
    modport slave (
        input  start, pad_sel, lit, clear,
        output busy, done, plot, x_out, y_out, colour_out
    );
`else
    modport master (
        output start, pad_sel, lit,
        input  busy, done, plot, x_out, y_out, colour_out
    );
    modport slave (
        input  start, pad_sel, lit,
        output busy, done, plot, x_out, y_out, colour_out
    );
`endif
endinterface

// File: rtl/pad_draw_fsm.sv
// Pad draw sequencer: one registered pixel per cycle, first plot one edge after start is accepted; start ignored while busy.
// PAD_DRAW_CLEAR_EN adds a CLEAR state that blanks the whole 160x120 screen.
module pad_draw_fsm #(
    parameter int unsigned PAD_SIZE = 32,
    parameter int unsigned GRID_X   = 40,
    parameter int unsigned GRID_Y   = 20,
    parameter int unsigned GAP      = 8
) (
    input  logic          clk,
    input  logic          reset,
    pad_draw_fsm_if.slave bus
);

    localparam logic [7:0] PAD0_X  = 8'(GRID_X);
    localparam logic [7:0] PAD1_X  = 8'(GRID_X + PAD_SIZE + GAP);
    localparam logic [6:0] PAD0_Y  = 7'(GRID_Y);
    localparam logic [6:0] PAD2_Y  = 7'(GRID_Y + PAD_SIZE + GAP);
    localparam logic [7:0] LAST_CX = 8'(PAD_SIZE - 1);
    localparam logic [6:0] LAST_CY = 7'(PAD_SIZE - 1);

`ifdef PAD_DRAW_CLEAR_EN
    localparam logic [7:0] SCR_LAST_X = 8'd159;
    localparam logic [6:0] SCR_LAST_Y = 7'd119;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        DONE  = 2'd2,
        CLEAR = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [1:0] pad_q,   pad_d;
    logic       lit_q,   lit_d;
    logic [7:0] cx_q,    cx_d;
    logic [6:0] cy_q,    cy_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;
    logic       plot_q,  plot_d;
    logic [7:0] x_q,     x_d;
    logic [6:0] y_q,     y_d;
    logic [2:0] col_q,   col_d;

    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [2:0] base_col;
    logic       on_border;

    // Bit 0 of the pad index selects the right column, bit 1 the bottom row.
    assign base_x = pad_q[0] ? PAD1_X : PAD0_X;
    assign base_y = pad_q[1] ? PAD2_Y : PAD0_Y;

    always_comb begin
        base_col = 3'b010;
        unique case (pad_q)
            2'd0: base_col = 3'b010;
            2'd1: base_col = 3'b100;
            2'd2: base_col = 3'b110;
            2'd3: base_col = 3'b001;
            default: base_col = 3'b010;
        endcase
    end

    assign on_border = (cx_q == 8'd0) || (cx_q == LAST_CX) ||
                       (cy_q == 7'd0) || (cy_q == LAST_CY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pad_q   <= 2'd0;
            lit_q   <= 1'b0;
            cx_q    <= 8'd0;
            cy_q    <= 7'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            plot_q  <= 1'b0;
            x_q     <= 8'd0;
            y_q     <= 7'd0;
            col_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            pad_q   <= pad_d;
            lit_q   <= lit_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            plot_q  <= plot_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pad_d   = pad_q;
        lit_d   = lit_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        plot_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
`ifdef PAD_DRAW_CLEAR_EN
                if (bus.clear) begin
                    state_d = CLEAR;
                    cx_d    = 8'd0;
                    cy_d    = 7'd0;
                    busy_d  = 1'b1;
                end else
`endif
                if (bus.start) begin
                    state_d = DRAW;
                    pad_d   = bus.pad_sel;
                    lit_d   = bus.lit;
                    cx_d    = 8'd0;
                    cy_d    = 7'd0;
                    busy_d  = 1'b1;
                end
            end

            DRAW: begin
                busy_d = 1'b1;
                plot_d = 1'b1;
                x_d    = base_x + cx_q;
                y_d    = base_y + cy_q;
                col_d  = (lit_q || on_border) ? base_col : 3'b000;
                if (cx_q == LAST_CX) begin
                    cx_d = 8'd0;
                    if (cy_q == LAST_CY) begin
                        cy_d    = 7'd0;
                        state_d = DONE;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end

            DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end

`ifdef PAD_DRAW_CLEAR_EN
            CLEAR: begin
                busy_d = 1'b1;
                plot_d = 1'b1;
                x_d    = cx_q;
                y_d    = cy_q;
                col_d  = 3'b000;
                if (cx_q == SCR_LAST_X) begin
                    cx_d = 8'd0;
                    if (cy_q == SCR_LAST_Y) begin
                        cy_d    = 7'd0;
                        state_d = DONE;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.plot       = plot_q;
    assign bus.x_out      = x_q;
    assign bus.y_out      = y_q;
    assign bus.colour_out = col_q;

endmodule

// File: tb/tb_pad_draw_fsm.sv
// Bench for pad_draw_fsm: queue-based cycle model plus directed literal checks.
module tb_pad_draw_fsm;
    localparam int N    = 32;
    localparam int NCAP = 19200;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pad_draw_fsm_if bus();

    pad_draw_fsm #(.PAD_SIZE(32), .GRID_X(40), .GRID_Y(20), .GAP(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } rec_t;

    rec_t q[$];
    rec_t e = '0;

    function automatic logic [2:0] pad_colour(input logic [1:0] s);
        logic [2:0] t [4];
        t[0] = 3'b010; t[1] = 3'b100; t[2] = 3'b110; t[3] = 3'b001;
        return t[s];
    endfunction

    task automatic push_draw(input logic [1:0] s, input logic lt);
        rec_t r;
        int bx, by, cx, cy;
        bx = 40 + (s[0] ? 40 : 0);
        by = 20 + (s[1] ? 40 : 0);
        r = '0; r.busy = 1'b1;
        q.push_back(r);
        for (int i = 0; i < N * N; i++) begin
            cx = i % N; cy = i / N;
            r = '0; r.busy = 1'b1; r.plot = 1'b1;
            r.x = 8'(bx + cx);
            r.y = 7'(by + cy);
            r.c = (lt || cx == 0 || cy == 0 || cx == N - 1 || cy == N - 1) ? pad_colour(s) : 3'b000;
            q.push_back(r);
        end
        r = '0; r.busy = 1'b1; r.done = 1'b1;
        q.push_back(r);
    endtask

`ifdef PAD_DRAW_CLEAR_EN
    task automatic push_clear();
        rec_t r;
        r = '0; r.busy = 1'b1;
        q.push_back(r);
        for (int i = 0; i < 160 * 120; i++) begin
            r = '0; r.busy = 1'b1; r.plot = 1'b1;
            r.x = 8'(i % 160);
            r.y = 7'(i / 160);
            q.push_back(r);
        end
        r = '0; r.busy = 1'b1; r.done = 1'b1;
        q.push_back(r);
    endtask
`endif

    always @(posedge clk) begin
        rec_t r;
        if (reset) begin
            q.delete();
            e = '0;
        end else begin
            if (q.size() == 0) begin
`ifdef PAD_DRAW_CLEAR_EN
                if (bus.clear) push_clear();
                else
`endif
                if (bus.start) push_draw(bus.pad_sel, bus.lit);
            end
            if (q.size() != 0) begin
                r = q.pop_front();
                e.busy = r.busy; e.done = r.done; e.plot = r.plot;
                if (r.plot) begin e.x = r.x; e.y = r.y; e.c = r.c; end
            end else begin
                e.busy = 1'b0; e.done = 1'b0; e.plot = 1'b0;
            end
        end
    end

    // ---------------- checking and capture ----------------
    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;
    int np, nd;
    logic [7:0] cap_x [NCAP];
    logic [6:0] cap_y [NCAP];
    logic [2:0] cap_c [NCAP];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_on)
            chk("cycle", 32'({bus.busy, bus.done, bus.plot, bus.x_out, bus.y_out, bus.colour_out}), 32'(e));
        if (bus.plot === 1'b1) begin
            if (np < NCAP) begin
                cap_x[np] = bus.x_out; cap_y[np] = bus.y_out; cap_c[np] = bus.colour_out;
            end
            np++;
        end
        if (bus.done === 1'b1) nd++;
    endtask

    // kind 1: re-pulse start with pad_sel=1 at plot act_at; kind 3: pulse start periodically
    task automatic run(input int budget, input int act_at, input int kind);
        bit fired;
        fired = 1'b0;
        np = 0; nd = 0;
        for (int it = 0; it < budget && nd == 0; it++) begin
            tick();
            bus.start = 1'b0;
            if (kind == 1 && !fired && np == act_at) begin
                bus.start = 1'b1; bus.pad_sel = 2'd1; fired = 1'b1;
            end
            if (kind == 3 && (it % 1000) == 500) bus.start = 1'b1;
        end
        bus.start = 1'b0;
        chk("done_seen", 32'(nd), 32'd1);
    endtask

    task automatic pulse_start(input logic [1:0] s, input logic lt);
        bus.pad_sel = s; bus.lit = lt; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        int cnt;
        bus.start = 1'b0; bus.pad_sel = 2'd0; bus.lit = 1'b0;
`ifdef PAD_DRAW_CLEAR_EN
        bus.clear = 1'b0;
`endif
        np = 0; nd = 0;
        reset = 1'b1;
        tick();
        chk_on = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_outs", 32'({bus.busy, bus.done, bus.plot, bus.x_out, bus.y_out, bus.colour_out}), 32'd0);
        np = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("idle_no_plot", 32'(np), 32'd0);

        // pad0 lit
        pulse_start(2'd0, 1'b1);
        run(1100, -1, 0);
        chk("p0_count", 32'(np), 32'd1024);
        chk("p0_first", {cap_x[0], 1'b0, cap_y[0], 13'd0, cap_c[0]}, {8'd40, 1'b0, 7'd20, 13'd0, 3'b010});
        chk("p0_second", {cap_x[1], 1'b0, cap_y[1]}, {8'd41, 1'b0, 7'd20});
        chk("p0_33rd", {cap_x[32], 1'b0, cap_y[32]}, {8'd40, 1'b0, 7'd21});
        chk("p0_last", {cap_x[1023], 1'b0, cap_y[1023]}, {8'd71, 1'b0, 7'd51});
        tick();
        chk("p0_done_1cyc", 32'(bus.done), 32'd0);
        chk("p0_busy_low", 32'(bus.busy), 32'd0);

        // pad3 outline
        pulse_start(2'd3, 1'b0);
        run(1100, -1, 0);
        chk("p3_first", {cap_x[0], 1'b0, cap_y[0], 13'd0, cap_c[0]}, {8'd80, 1'b0, 7'd60, 13'd0, 3'b001});
        chk("p3_inner", {cap_x[165], 1'b0, cap_y[165], 13'd0, cap_c[165]}, {8'd85, 1'b0, 7'd65, 13'd0, 3'b000});
        chk("p3_edge", {cap_x[511], 1'b0, cap_y[511], 13'd0, cap_c[511]}, {8'd111, 1'b0, 7'd75, 13'd0, 3'b001});
        cnt = 0;
        for (int i = 0; i < np && i < NCAP; i++) if (cap_c[i] == 3'b001) cnt++;
        chk("p3_border_cnt", 32'(cnt), 32'd124);
        tick(); tick();

        // start re-pulsed mid-draw is ignored
        pulse_start(2'd0, 1'b1);
        run(1100, 100, 1);
        chk("rp_count", 32'(np), 32'd1024);
        cnt = 0;
        for (int i = 0; i < np && i < NCAP; i++) if (cap_x[i] < 8'd40 || cap_x[i] > 8'd71) cnt++;
        chk("rp_x_range", 32'(cnt), 32'd0);
        tick(); tick();

        // reset in the middle of a pad2 draw
        pulse_start(2'd2, 1'b1);
        np = 0; nd = 0;
        for (int it = 0; it < 1100 && np < 500; it++) tick();
        chk("mid_plots", 32'(np), 32'd500);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_plot_busy", 32'({bus.plot, bus.busy}), 32'd0);
        nd = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_no_done", 32'(nd), 32'd0);
        pulse_start(2'd2, 1'b1);
        run(1100, -1, 0);
        chk("p2_first", {cap_x[0], 1'b0, cap_y[0], 13'd0, cap_c[0]}, {8'd40, 1'b0, 7'd60, 13'd0, 3'b110});
        tick(); tick();

`ifdef PAD_DRAW_CLEAR_EN
        bus.clear = 1'b1; bus.start = 1'b1; bus.pad_sel = 2'd1; bus.lit = 1'b1;
        tick();
        bus.clear = 1'b0; bus.start = 1'b0;
        run(19300, -1, 3);
        chk("clr_count", 32'(np), 32'd19200);
        chk("clr_first", {cap_x[0], 1'b0, cap_y[0]}, {8'd0, 1'b0, 7'd0});
        chk("clr_last", {cap_x[NCAP-1], 1'b0, cap_y[NCAP-1]}, {8'd159, 1'b0, 7'd119});
        cnt = 0;
        for (int i = 0; i < np && i < NCAP; i++) if (cap_c[i] != 3'b000) cnt++;
        chk("clr_black", 32'(cnt), 32'd0);
        tick(); tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
